// File: rtl/char_pkg.sv
// char_pkg: shared attribute struct, shifter state enum and pixel helper for the character pipeline.
package char_pkg;
  localparam int COLOR_W = 24;
  typedef struct packed {
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic               ul;
    logic               rev;
    logic               blink;
  } char_attr_t;
  typedef enum logic [1:0] {BLANK, SHIFT, HOLD} state_t;
  // Blink blanking hides both glyph and underline; inversion applies afterwards.
  function automatic logic pix_on(input logic b, input logic ul_hit, input logic invert, input logic blank);
    return ((b | ul_hit) & ~blank) ^ invert;
  endfunction
endpackage

// File: rtl/char_blink_ctr.sv
// char_blink_ctr: free-running frame counter driving text blink and cursor blink.
module char_blink_ctr #(
  parameter int pBlinkBits = 5
) (
  input  logic                  dot_clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_i,
  output logic [pBlinkBits-1:0] blink_ctr
);
  always_ff @(posedge dot_clk_i or negedge rst_ni)
    if (!rst_ni) blink_ctr <= '0;
    else if (frame_i) blink_ctr <= blink_ctr + pBlinkBits'(1);
endmodule

// File: rtl/char_pixel_shifter.sv
// char_pixel_shifter: serialises a glyph scanline into coloured pixels, one per dot clock.
// Attributes lag one cell so they line up with the glyph bitmap arriving from char_ram.
module char_pixel_shifter import char_pkg::*; #(
  parameter int pColorBits = 24,
  parameter int pBlinkBits = 5
) (
  input  logic                  dot_clk_i,
  input  logic                  rst_ni,
  input  logic                  ce_i,
  input  logic [63:0]           bmp_i,
  input  logic [5:0]            maxScanpix_i,
  input  logic [5:0]            maxscanline_i,
  input  logic [5:0]            scanline_i,
  input  logic                  de_i,
  input  char_attr_t            attr_i,
  input  logic                  cursor_i,
  input  logic                  frame_i,
  output logic [pColorBits-1:0] rgb_o,
  output logic                  de_o
);
  state_t state, state_n;
  logic [63:0] sr;
  logic [5:0] cnt;
  char_attr_t attr_d, attr_c, pa;
  logic cur_d, cur_c, de_d, pc, bit_n, p, show_pix, de_n;
  logic [pColorBits-1:0] rgb_n;
  logic [pBlinkBits-1:0] blink_ctr;
  logic unused_blink;

  char_blink_ctr #(.pBlinkBits(pBlinkBits)) u_blink (
    .dot_clk_i(dot_clk_i),
    .rst_ni(rst_ni),
    .frame_i(frame_i),
    .blink_ctr(blink_ctr)
  );

  assign unused_blink = ^blink_ctr[pBlinkBits-3:0];

  always_ff @(posedge dot_clk_i or negedge rst_ni)
    if (!rst_ni) state <= BLANK;
    else state <= state_n;

  always_comb
    state_n = ce_i ? (de_d ? SHIFT : BLANK) : (state == SHIFT && cnt == '0) ? HOLD : state;

  // On ce the first pixel comes straight from bmp_i so it appears one cycle later.
  always_comb begin
    pa       = ce_i ? attr_d : attr_c;
    pc       = ce_i ? cur_d : cur_c;
    bit_n    = ce_i ? bmp_i[maxScanpix_i] : sr[cnt - 6'd1];
    p        = pix_on(bit_n, pa.ul & (scanline_i == maxscanline_i),
                      pa.rev ^ (pc & ~blink_ctr[pBlinkBits-2]), pa.blink & blink_ctr[pBlinkBits-1]);
    show_pix = ce_i ? de_d : (state == SHIFT && cnt != '0);
    de_n     = ce_i ? de_d : state != BLANK;
    rgb_n    = show_pix ? (p ? pColorBits'(pa.fg) : pColorBits'(pa.bg)) : de_n ? pColorBits'(pa.bg) : '0;
  end

  always_ff @(posedge dot_clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sr     <= '0;
      cnt    <= '0;
      attr_d <= '0;
      attr_c <= '0;
      cur_d  <= 1'b0;
      cur_c  <= 1'b0;
      de_d   <= 1'b0;
      rgb_o  <= '0;
      de_o   <= 1'b0;
    end else begin
      rgb_o <= rgb_n;
      de_o  <= de_n;
      if (ce_i) begin
        sr     <= bmp_i;
        cnt    <= maxScanpix_i;
        attr_c <= attr_d;
        cur_c  <= cur_d;
        attr_d <= attr_i;
        cur_d  <= cursor_i;
        de_d   <= de_i;
      end else if (state == SHIFT && cnt != '0) cnt <= cnt - 6'd1;
    end
endmodule
